bc_buffer_mc: RTL and testbench
===============================

// Module: bc_buffer_mc
// PURPOSE
//  Parametrised bidirectional bridge buffer between the avoidance block and the controller.
//  Two independent ready/valid FIFOs:
//   - c2a: ctrl_in -> avoid_out
//   - a2c: avoid_in -> ctrl_out
//  Adds to the previous buffer: configurable width/depth, occupancy level, almost-full flag and per-direction flush.
// PARAMETERS
//  DATA_W     16         payload width, bits (>=1)
//  DEPTH      16         entries per direction; power of 2, >=2
//  AFULL_LVL  DEPTH-2    level at or above which *_afull asserts (1..DEPTH)
// PORTS
//  clk              in   1          single clock, rising edge
//  rst              in   1          reset: synchronous, active-low
//  ctrl_in_valid    in   1          c2a write request
//  ctrl_in_data     in   DATA_W     c2a write data
//  ctrl_in_rdy      out  1          c2a can accept
//  avoid_out_rdy    in   1          c2a read request
//  avoid_out_valid  out  1          c2a head word present
//  avoid_out_data   out  DATA_W     c2a head word
//  avoid_in_valid   in   1          a2c write request
//  avoid_in_data    in   DATA_W     a2c write data
//  avoid_in_rdy     out  1          a2c can accept
//  ctrl_out_rdy     in   1          a2c read request
//  ctrl_out_valid   out  1          a2c head word present
//  ctrl_out_data    out  DATA_W     a2c head word
//  c2a_flush        in   1          discard all c2a contents
//  a2c_flush        in   1          discard all a2c contents
//  c2a_level        out  LVL_W      c2a occupancy, LVL_W=$clog2(DEPTH+1)
//  a2c_level        out  LVL_W      a2c occupancy
//  c2a_afull        out  1          c2a_level >= AFULL_LVL
//  a2c_afull        out  1          a2c_level >= AFULL_LVL
// BEHAVIOUR (per direction, identical and independent)
//  - Reset (rst==0 at an edge): pointers/level cleared.
//     *_in_rdy=0, *_out_valid=0, *_out_data=0, *_level=0, *_afull=0.
//     *_in_rdy rises on the first edge with rst==1. Reset mid-transfer drops all content.
//  - Push occurs at an edge when in_valid && in_rdy. Pop occurs when out_valid && out_rdy.
//  - in_rdy is registered, == (level<DEPTH); no combinational path from out_rdy to in_rdy.
//  - Full + pop in the same cycle: push is refused (in_rdy=0); in_rdy returns 1 the cycle after the pop.
//  - Empty: pop is impossible (out_valid=0); out_rdy is ignored.
//  - Show-ahead output: out_data is the head word whenever out_valid=1; out_data holds its last value when empty.
//  - Latency: a word pushed at edge k is visible (out_valid=1) after edge k; back-to-back 1 word/cycle sustained.
//  - Simultaneous push and pop when 0<level<DEPTH: level unchanged; both performed.
//  - Simultaneous push and pop when level==0: the push lands; out_valid=1 next cycle.
//  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; level is tracked separately (no extra MSB compare).
//  - Flush: priority over push/pop in the same cycle.
//     Result: level=0, out_valid=0, in_rdy=1 next cycle; the push in the flush cycle is discarded.
//  - level and afull are registered and reflect the state after the edge.
//  - Ordering is strict FIFO; no data reordering or duplication.
// CONFIGURATION
//  BC_BUFFER_STATS_EN defined: extra outputs c2a_push_cnt and a2c_push_cnt, each out 32.
//   - Count accepted pushes; saturate at 32'hFFFF_FFFF.
//   - Cleared by reset, not by flush.
//  Undefined: the ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  Package bc_buffer_pkg:
//   - BC_DATA_W_DEF=16, BC_DEPTH_DEF=16
//   - function lvl_w(depth) = $clog2(depth+1)
//   - typedef struct {valid, data} bc_word_t, parametrised via DATA_W localparam
//  Sub-module bc_fifo: one ready/valid FIFO with flush/level/afull, instantiated twice (c2a, a2c).
//  Top is wiring plus optional stats counters.
// TESTING
//  1 Release reset, push 10 words 0x000A..0x0013 on ctrl_in with avoid_out_rdy=0.
//     -> c2a_level=10, avoid_out pops 0x000A..0x0013 in order.
//  2 DEPTH=16: push 16 words, no pop.
//     -> ctrl_in_rdy=0 after the 16th edge, c2a_afull=1 from level 14; the 17th word is not accepted.
//  3 Full FIFO: hold avoid_out_valid/rdy=1 and ctrl_in_valid=1.
//     -> in_rdy toggles, throughput settles to 1 pop/cycle, no loss/dup (scoreboard).
//  4 Empty FIFO: push 0x1234 at edge k with ctrl_out_rdy=1.
//     -> ctrl_out_valid=1, data=0x1234 after k; popped at k+1; level returns to 0.
//  5 Level 5: assert a2c_flush together with avoid_in_valid=1, data=0xBEEF.
//     -> next cycle a2c_level=0, ctrl_out_valid=0; 0xBEEF never appears.
//  6 Drive rst=0 for one edge at level 7 mid-stream.
//     -> all outputs are reset values; after release the fresh sequence 0x0001..0x0003 round-trips intact.

Source files
------------

// File: rtl/bc_buffer_pkg.sv
// rtl/bc_buffer_pkg.sv - shared defaults, sizing helper and word type for the bridge buffer
// Purpose: default geometry of bc_buffer_mc, level-width helper, packed word type.
package bc_buffer_pkg;

  localparam int BC_DATA_W_DEF = 16;
  localparam int BC_DEPTH_DEF  = 16;
  localparam int BC_WORD_W     = BC_DATA_W_DEF;

  // Occupancy must represent 0..depth inclusive.
  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic                 valid;
    logic [BC_WORD_W-1:0] data;
  } bc_word_t;

endpackage

// File: rtl/bc_fifo.sv
// rtl/bc_fifo.sv - single-clock show-ahead ready/valid FIFO with flush, level and almost-full
// Purpose: one direction of the bridge buffer.
// Ports: clk_i, rst_ni (sync, active-low), flush_i,
//        in_valid_i/in_data_i/in_rdy_o (write side),
//        out_rdy_i/out_valid_o/out_data_o (read side, head word shown ahead),
//        level_o (occupancy), afull_o (level_o >= AFULL_LVL). All outputs registered.
module bc_fifo
  import bc_buffer_pkg::*;
#(
  parameter  int DATA_W    = BC_DATA_W_DEF,
  parameter  int DEPTH     = BC_DEPTH_DEF,
  parameter  int AFULL_LVL = DEPTH - 2,
  localparam int LVL_W     = lvl_w(DEPTH),
  localparam int PTR_W     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_rdy_o,
  input  logic              out_rdy_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [LVL_W-1:0]  level_o,
  output logic              afull_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              in_rdy_q, in_rdy_d, out_valid_q, out_valid_d, afull_q, afull_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              push, pop;

  always_comb begin
    push        = in_valid_i && in_rdy_q;
    pop         = out_valid_q && out_rdy_i;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    out_data_d  = out_data_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      level_d = level_q + LVL_W'(push) - LVL_W'(pop);
      // The head register must hold the word that is at the front after this edge.
      // When the FIFO holds at most one word, that word may be the one arriving now.
      if (pop) begin
        if (level_q >= LVL_W'(2))
          out_data_d = mem_q[rd_ptr_q + PTR_W'(1)];
        else if (push)
          out_data_d = in_data_i;
      end else if (level_q == '0 && push) begin
        out_data_d = in_data_i;
      end
    end
    in_rdy_d    = level_d < LVL_W'(DEPTH);
    out_valid_d = level_d != '0;
    afull_d     = level_d >= LVL_W'(AFULL_LVL);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      in_rdy_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      afull_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      in_rdy_q    <= in_rdy_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      afull_q     <= afull_d;
    end
  end

  // Storage is not reset; validity is carried by level/pointers.
  always_ff @(posedge clk_i) begin
    if (rst_ni && push && !flush_i) mem_q[wr_ptr_q] <= in_data_i;
  end

  assign in_rdy_o    = in_rdy_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign level_o     = level_q;
  assign afull_o     = afull_q;

endmodule

// File: rtl/bc_buffer_mc.sv
// rtl/bc_buffer_mc.sv - bidirectional bridge buffer between controller and avoidance block
// Purpose: two independent FIFOs, c2a (ctrl_in -> avoid_out) and a2c (avoid_in -> ctrl_out).
// Ports: clk, rst (sync, active-low); per direction write side *_in_valid/_data/_rdy,
//        read side *_out_rdy/_valid/_data, *_flush, *_level, *_afull.
// Option BC_BUFFER_STATS_EN: adds c2a_push_cnt/a2c_push_cnt, saturating counts of pushes
//        that land in the FIFO; cleared by reset only.
module bc_buffer_mc
  import bc_buffer_pkg::*;
#(
  parameter  int DATA_W    = BC_DATA_W_DEF,
  parameter  int DEPTH     = BC_DEPTH_DEF,
  parameter  int AFULL_LVL = DEPTH - 2,
  localparam int LVL_W     = lvl_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctrl_in_valid,
  input  logic [DATA_W-1:0] ctrl_in_data,
  output logic              ctrl_in_rdy,
  input  logic              avoid_out_rdy,
  output logic              avoid_out_valid,
  output logic [DATA_W-1:0] avoid_out_data,
  input  logic              avoid_in_valid,
  input  logic [DATA_W-1:0] avoid_in_data,
  output logic              avoid_in_rdy,
  input  logic              ctrl_out_rdy,
  output logic              ctrl_out_valid,
  output logic [DATA_W-1:0] ctrl_out_data,
  input  logic              c2a_flush,
  input  logic              a2c_flush,
  output logic [LVL_W-1:0]  c2a_level,
  output logic [LVL_W-1:0]  a2c_level,
  output logic              c2a_afull,
  output logic              a2c_afull
`ifdef BC_BUFFER_STATS_EN
  ,
  output logic [31:0]       c2a_push_cnt,
  output logic [31:0]       a2c_push_cnt
`endif
);

  bc_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_LVL(AFULL_LVL)) u_c2a (
    .clk_i(clk), .rst_ni(rst), .flush_i(c2a_flush),
    .in_valid_i(ctrl_in_valid), .in_data_i(ctrl_in_data), .in_rdy_o(ctrl_in_rdy),
    .out_rdy_i(avoid_out_rdy), .out_valid_o(avoid_out_valid), .out_data_o(avoid_out_data),
    .level_o(c2a_level), .afull_o(c2a_afull)
  );

  bc_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_LVL(AFULL_LVL)) u_a2c (
    .clk_i(clk), .rst_ni(rst), .flush_i(a2c_flush),
    .in_valid_i(avoid_in_valid), .in_data_i(avoid_in_data), .in_rdy_o(avoid_in_rdy),
    .out_rdy_i(ctrl_out_rdy), .out_valid_o(ctrl_out_valid), .out_data_o(ctrl_out_data),
    .level_o(a2c_level), .afull_o(a2c_afull)
  );

`ifdef BC_BUFFER_STATS_EN
  // A push discarded by a same-cycle flush never entered the FIFO and is not counted.
  logic c2a_push, a2c_push;
  assign c2a_push = ctrl_in_valid && ctrl_in_rdy && !c2a_flush;
  assign a2c_push = avoid_in_valid && avoid_in_rdy && !a2c_flush;

  always_ff @(posedge clk) begin
    if (!rst) begin
      c2a_push_cnt <= '0;
      a2c_push_cnt <= '0;
    end else begin
      if (c2a_push && c2a_push_cnt != 32'hFFFF_FFFF) c2a_push_cnt <= c2a_push_cnt + 32'd1;
      if (a2c_push && a2c_push_cnt != 32'hFFFF_FFFF) a2c_push_cnt <= a2c_push_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bc_buffer_mc.sv
// tb/tb_bc_buffer_mc.sv - directed self-checking bench for bc_buffer_mc
module tb_bc_buffer_mc;

  localparam int DW = 16;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ctrl_in_valid = 1'b0, avoid_out_rdy = 1'b0;
  logic          avoid_in_valid = 1'b0, ctrl_out_rdy = 1'b0;
  logic          c2a_flush = 1'b0, a2c_flush = 1'b0;
  logic [DW-1:0] ctrl_in_data = '0, avoid_in_data = '0;
  logic          ctrl_in_rdy, avoid_out_valid, avoid_in_rdy, ctrl_out_valid;
  logic [DW-1:0] avoid_out_data, ctrl_out_data;
  logic [LW-1:0] c2a_level, a2c_level;
  logic          c2a_afull, a2c_afull;
`ifdef BC_BUFFER_STATS_EN
  logic [31:0]   c2a_push_cnt, a2c_push_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  bc_buffer_mc dut (
    .clk(clk), .rst(rst),
    .ctrl_in_valid(ctrl_in_valid), .ctrl_in_data(ctrl_in_data), .ctrl_in_rdy(ctrl_in_rdy),
    .avoid_out_rdy(avoid_out_rdy), .avoid_out_valid(avoid_out_valid), .avoid_out_data(avoid_out_data),
    .avoid_in_valid(avoid_in_valid), .avoid_in_data(avoid_in_data), .avoid_in_rdy(avoid_in_rdy),
    .ctrl_out_rdy(ctrl_out_rdy), .ctrl_out_valid(ctrl_out_valid), .ctrl_out_data(ctrl_out_data),
    .c2a_flush(c2a_flush), .a2c_flush(a2c_flush),
    .c2a_level(c2a_level), .a2c_level(a2c_level),
    .c2a_afull(c2a_afull), .a2c_afull(a2c_afull)
`ifdef BC_BUFFER_STATS_EN
    , .c2a_push_cnt(c2a_push_cnt), .a2c_push_cnt(a2c_push_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " c2a in_rdy"}, 32'(ctrl_in_rdy), 0);
    chk({tag, " c2a out_valid"}, 32'(avoid_out_valid), 0);
    chk({tag, " c2a out_data"}, 32'(avoid_out_data), 0);
    chk({tag, " c2a level"}, 32'(c2a_level), 0);
    chk({tag, " c2a afull"}, 32'(c2a_afull), 0);
    chk({tag, " a2c in_rdy"}, 32'(avoid_in_rdy), 0);
    chk({tag, " a2c out_valid"}, 32'(ctrl_out_valid), 0);
    chk({tag, " a2c level"}, 32'(a2c_level), 0);
    chk({tag, " a2c afull"}, 32'(a2c_afull), 0);
  endtask

  logic [DW-1:0] sb[$];
  logic [DW-1:0] nxt;
  int            pops;

  initial begin
    // Reset
    step(); step();
    chk_reset_state("rst");
    rst = 1'b1;
    step();
    chk("rst rel c2a in_rdy", 32'(ctrl_in_rdy), 1);
    chk("rst rel a2c in_rdy", 32'(avoid_in_rdy), 1);

    // 1: ten words in, then drained in order
    for (int i = 0; i < 10; i++) begin
      ctrl_in_valid = 1'b1; ctrl_in_data = DW'(16'h000A + i);
      step();
    end
    ctrl_in_valid = 1'b0;
    chk("t1 level", 32'(c2a_level), 10);
    chk("t1 afull", 32'(c2a_afull), 0);
    avoid_out_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("t1 valid", 32'(avoid_out_valid), 1);
      chk("t1 data", 32'(avoid_out_data), 32'h000A + i);
      step();
    end
    avoid_out_rdy = 1'b0;
    chk("t1 empty valid", 32'(avoid_out_valid), 0);
    chk("t1 empty level", 32'(c2a_level), 0);
    chk("t1 data held", 32'(avoid_out_data), 32'h0013);

    // 2: fill to DEPTH, afull from 14, 17th refused
    for (int i = 0; i < 16; i++) begin
      ctrl_in_valid = 1'b1; ctrl_in_data = DW'(16'h0100 + i);
      step();
      chk("t2 level", 32'(c2a_level), i + 1);
      chk("t2 afull", 32'(c2a_afull), (i + 1 >= 14) ? 1 : 0);
    end
    chk("t2 full in_rdy", 32'(ctrl_in_rdy), 0);
    ctrl_in_data = 16'hDEAD;
    step(); step();
    ctrl_in_valid = 1'b0;
    chk("t2 17th level", 32'(c2a_level), 16);
    avoid_out_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t2 drain data", 32'(avoid_out_data), 32'h0100 + i);
      step();
    end
    avoid_out_rdy = 1'b0;
    chk("t2 drained valid", 32'(avoid_out_valid), 0);

    // 3: full FIFO with continuous push and pop, scoreboarded
    for (int i = 0; i < 16; i++) begin
      ctrl_in_valid = 1'b1; ctrl_in_data = DW'(16'h0200 + i);
      sb.push_back(DW'(16'h0200 + i));
      step();
    end
    chk("t3 full in_rdy", 32'(ctrl_in_rdy), 0);
    nxt = 16'h0300; ctrl_in_data = nxt;
    avoid_out_rdy = 1'b1;
    pops = 0;
    for (int c = 0; c < 40; c++) begin
      logic do_push, do_pop;
      do_push = ctrl_in_valid && ctrl_in_rdy;
      do_pop  = avoid_out_valid && avoid_out_rdy;
      if (do_pop) begin
        pops++;
        if (sb.size() == 0) chk("t3 sb underflow", 1, 0);
        else chk("t3 data", 32'(avoid_out_data), 32'(sb.pop_front()));
      end
      if (do_push) sb.push_back(ctrl_in_data);
      step();
      if (do_push) begin nxt = nxt + 16'd1; ctrl_in_data = nxt; end
    end
    chk("t3 pops per cycle", 32'(pops), 40);
    chk("t3 in_rdy steady", 32'(ctrl_in_rdy), 1);
    ctrl_in_valid = 1'b0;
    for (int c = 0; c < 40 && avoid_out_valid; c++) begin
      if (sb.size() == 0) chk("t3 sb underflow", 1, 0);
      else chk("t3 drain", 32'(avoid_out_data), 32'(sb.pop_front()));
      step();
    end
    avoid_out_rdy = 1'b0;
    chk("t3 sb empty", 32'(sb.size()), 0);
    chk("t3 level", 32'(c2a_level), 0);

    // 4: a2c empty, pushed word visible next cycle, popped the cycle after
    ctrl_out_rdy = 1'b1;
    avoid_in_valid = 1'b1; avoid_in_data = 16'h1234;
    step();
    avoid_in_valid = 1'b0;
    chk("t4 valid", 32'(ctrl_out_valid), 1);
    chk("t4 data", 32'(ctrl_out_data), 32'h1234);
    chk("t4 level", 32'(a2c_level), 1);
    step();
    chk("t4 popped valid", 32'(ctrl_out_valid), 0);
    chk("t4 popped level", 32'(a2c_level), 0);
    ctrl_out_rdy = 1'b0;

    // 5: flush at level 5 wins over a concurrent push
    for (int i = 0; i < 5; i++) begin
      avoid_in_valid = 1'b1; avoid_in_data = DW'(16'h0050 + i);
      step();
    end
    chk("t5 level", 32'(a2c_level), 5);
    a2c_flush = 1'b1; avoid_in_data = 16'hBEEF;
    step();
    a2c_flush = 1'b0; avoid_in_valid = 1'b0;
    chk("t5 flush level", 32'(a2c_level), 0);
    chk("t5 flush valid", 32'(ctrl_out_valid), 0);
    chk("t5 flush in_rdy", 32'(avoid_in_rdy), 1);
    avoid_in_valid = 1'b1; avoid_in_data = 16'h0077;
    step();
    avoid_in_valid = 1'b0;
    chk("t5 post level", 32'(a2c_level), 1);
    chk("t5 post head", 32'(ctrl_out_data), 32'h0077);
    ctrl_out_rdy = 1'b1;
    step();
    ctrl_out_rdy = 1'b0;
    chk("t5 post empty", 32'(ctrl_out_valid), 0);

    // 6: reset mid-stream at level 7
    for (int i = 0; i < 7; i++) begin
      ctrl_in_valid = 1'b1; ctrl_in_data = DW'(16'h0400 + i);
      step();
    end
    ctrl_in_valid = 1'b0;
    chk("t6 level", 32'(c2a_level), 7);
    rst = 1'b0;
    step();
    chk_reset_state("t6 rst");
    rst = 1'b1;
    step();
    for (int i = 1; i <= 3; i++) begin
      ctrl_in_valid = 1'b1; ctrl_in_data = DW'(i);
      step();
    end
    ctrl_in_valid = 1'b0;
    chk("t6 fresh level", 32'(c2a_level), 3);
    avoid_out_rdy = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      chk("t6 fresh valid", 32'(avoid_out_valid), 1);
      chk("t6 fresh data", 32'(avoid_out_data), i);
      step();
    end
    avoid_out_rdy = 1'b0;
    chk("t6 end valid", 32'(avoid_out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
